// File: rtl/novo_mips_pkg.sv
// Shared types and encodings for the novo MIPS pipeline.
// The scoreboard slot entry lives here so the top and the lookup agree on its layout.
package novo_mips_pkg;

  // Width of the destination field in a slot entry; widen this if REG_ADDR_W grows.
  localparam int SB_RD_W = 5;

  typedef struct packed {
    logic               valid;
    logic [SB_RD_W-1:0] rd;
    logic               is_load;
  } sb_entry_t;

  localparam logic [5:0] OP_RTYPE   = 6'b000000;
  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] OP_ADDI    = 6'b001000;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_J       = 6'b000010;

endpackage

// File: rtl/sb_operand_lookup.sv
// Resolves one decode operand against the in-flight slots: the youngest matching
// writer decides between a hazard, a forwarded result, or register-file data.
module sb_operand_lookup
  import novo_mips_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_RDY   = 2
) (
  input  sb_entry_t [DEPTH-1:0]       slots,
  input  logic [REG_ADDR_W-1:0]       src,
  input  logic                        src_used,
  input  logic [DATA_W-1:0]           rf_data,
  input  logic [DEPTH*DATA_W-1:0]     res_data,
  output logic                        hazard,
  output logic [DATA_W-1:0]           data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic             found;
  logic [IDX_W-1:0] sel;

  // Slot 0 is the youngest, so the first hit in ascending order wins.
  always_comb begin
    found  = 1'b0;
    sel    = '0;
    hazard = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!found && src_used && (src != '0) && slots[k].valid &&
          (slots[k].rd == SB_RD_W'(src))) begin
        found  = 1'b1;
        sel    = IDX_W'(k);
        hazard = (k < 1) || (slots[k].is_load && (k < LOAD_RDY));
      end
    end
    data = (found && !hazard) ? res_data[sel*DATA_W +: DATA_W] : rf_data;
  end

endmodule

// File: rtl/mips_scoreboard_fwd.sv
// Decode-stage scoreboard: shifts in-flight register writes from EX to WB,
// raises stall on unresolved dependences and forwards ready results.
module mips_scoreboard_fwd
  import novo_mips_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_RDY   = 2,
  parameter int CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        id_valid,
  input  logic [REG_ADDR_W-1:0]       id_rs,
  input  logic [REG_ADDR_W-1:0]       id_rt,
  input  logic                        id_rs_used,
  input  logic                        id_rt_used,
  input  logic                        id_wr_en,
  input  logic [REG_ADDR_W-1:0]       id_rd,
  input  logic                        id_is_load,
  input  logic                        flush,
  input  logic [DATA_W-1:0]           rf_rs_data,
  input  logic [DATA_W-1:0]           rf_rt_data,
  input  logic [DEPTH*DATA_W-1:0]     res_data,
  output logic                        stall,
  output logic [DATA_W-1:0]           id_rs_data,
  output logic [DATA_W-1:0]           id_rt_data,
  output logic [2**REG_ADDR_W-1:0]    pending_mask,
  output logic [CNT_W-1:0]            stall_cnt
);

  sb_entry_t [DEPTH-1:0] slots;
  sb_entry_t             new_entry;
  logic                  hazard_rs;
  logic                  hazard_rt;
  logic                  issue;

  sb_operand_lookup #(
    .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .DEPTH(DEPTH), .LOAD_RDY(LOAD_RDY)
  ) u_lookup_rs (
    .slots(slots), .src(id_rs), .src_used(id_rs_used), .rf_data(rf_rs_data),
    .res_data(res_data), .hazard(hazard_rs), .data(id_rs_data)
  );

  sb_operand_lookup #(
    .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .DEPTH(DEPTH), .LOAD_RDY(LOAD_RDY)
  ) u_lookup_rt (
    .slots(slots), .src(id_rt), .src_used(id_rt_used), .rf_data(rf_rt_data),
    .res_data(res_data), .hazard(hazard_rt), .data(id_rt_data)
  );

  // A flushed instruction never stalls and never enters EX.
  assign stall = id_valid & ~flush & (hazard_rs | hazard_rt);
  assign issue = id_valid & id_wr_en & (id_rd != '0) & ~stall & ~flush;

  assign new_entry = '{valid: 1'b1, rd: SB_RD_W'(id_rd), is_load: id_is_load};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slots <= '0;
    end else begin
      slots[0] <= issue ? new_entry : '0;
      for (int k = 1; k < DEPTH; k++) begin
        slots[k] <= slots[k-1];
      end
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (slots[k].valid) begin
        pending_mask[REG_ADDR_W'(slots[k].rd)] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: doc/mips_scoreboard_fwd.md
# mips_scoreboard_fwd

Parametrised scoreboard and decode-stage forwarding unit for the novo MIPS pipeline. It tracks every in-flight register write from EX through WB in a slot pipeline. It raises `stall` when a decode operand depends on a result that is not yet produced, and otherwise supplies the operand from the youngest producing stage or from the register file. It sits beside the register-file read in ID; the core uses `stall` to hold PC and IR_1 and to inject a bubble into EX.

## Interface
Parameters:
- `DATA_W`, 32, operand/result width
- `REG_ADDR_W`, 5, register index width; register 0 is hard-wired zero
- `DEPTH`, 3, tracked slots after ID (slot 0 = EX, 1 = MEM, 2 = WB)
- `LOAD_RDY`, 2, first slot at which a load result is valid (ALU results valid from slot 1)
- `CNT_W`, 16, stall counter width

Ports:
- `clk`  in  1  clock, single domain
- `rst`  in  1  asynchronous, active-high reset
- `id_valid`  in  1  ID holds a real instruction
- `id_rs`, `id_rt`  in  REG_ADDR_W  source indices
- `id_rs_used`, `id_rt_used`  in  1  source actually read
- `id_wr_en`  in  1  instruction writes a register
- `id_rd`  in  REG_ADDR_W  destination (already resolved for R/I type)
- `id_is_load`  in  1  instruction is lw
- `flush`  in  1  discard the ID instruction this cycle (taken beq/j in EX)
- `rf_rs_data`, `rf_rt_data`  in  DATA_W  register-file read data
- `res_data`  in  DEPTH*DATA_W  result register of each slot; slot k at bits [k*DATA_W +: DATA_W]; slot 0 ignored
- `stall`  out  1  hold ID/IF, bubble into EX
- `id_rs_data`, `id_rt_data`  out  DATA_W  resolved operands
- `pending_mask`  out  2**REG_ADDR_W  bit r set if any valid slot writes r
- `stall_cnt`  out  CNT_W  saturating count of stall cycles

## Operation
- Slot entry: {valid, rd, is_load}. Every clock the entries shift slot k → k+1; slot DEPTH-1 retires.
- Slot 0 loads {1, id_rd, id_is_load} when `issue = id_valid & id_wr_en & id_rd != 0 & !stall & !flush`; otherwise it loads invalid.
- Operand lookup (rs, rt independently): match = valid & rd == src & src != 0 & src_used. The lowest matching slot k wins.
  - Ready: k ≥ 1 for ALU; k ≥ LOAD_RDY for load.
  - Not ready → hazard.
  - Ready → operand = res_data slot k.
  - No match → operand = rf data.
- `stall = id_valid & !flush & (hazard_rs | hazard_rt)`.
- `flush` wins over stall: stall is 0, nothing is inserted, and the counter is not incremented.
- `stall_cnt` increments on each cycle with stall = 1 and saturates at all-ones.
- Register-file write in WB is not write-through, so slot DEPTH-1 is always forwarded.

## Timing
- `stall`, operands and `pending_mask` are combinational from current slots and id_* inputs in the same cycle. There are no combinational paths from outputs to inputs.
- Dependent ALU back-to-back: 1 stall cycle. Load-use: LOAD_RDY stall cycles (2 by default).
- Reset (async, any time): all slots invalid, `stall` = 0, `pending_mask` = 0, `stall_cnt` = 0. Operands pass rf data.
- Reset asserted mid-stall: the stall drops immediately, with no residual entries.
- Slot index width is $clog2(DEPTH). Requires DEPTH ≥ LOAD_RDY + 1.

## Structure
- Package `novo_mips_pkg`:
  - `sb_entry_t` struct
  - opcode/funct constants: R-type 000000, add 100000, sub 100010, addi 001000, lw 100011, sw 101011, beq 000100, j 000010
- Sub-module `sb_operand_lookup`: priority search, ready test and data mux for one source; instantiated twice.
- Top: slot shift register, issue logic, mask, counter.

## Test plan
- add r3,r1,r2 issued, then add r4,r3,r3 in ID next cycle:
  - stall = 1 for one cycle
  - then both operands = res_data slot 1 (e.g. 0x0000_0007)
  - stall_cnt = 1
- lw r5 issued, then add r6,r5,r0:
  - stall = 1 for two cycles
  - then rs = res_data slot 2
  - rt = rf data (r0, no hazard)
- addi r0,r1,5 followed by reader of r0: no stall, and pending_mask bit 0 stays 0.
- add r7 then sub r7 in flight (slots 2 and 1), reader of r7 in ID: operand = slot 1 value (youngest), not slot 2.
- Hazard present with flush = 1: stall = 0, slot 0 invalid next cycle, stall_cnt unchanged.
- Async rst pulse during a load-use stall: stall falls within the reset cycle, pending_mask = 0, and the following reader gets rf data with no stall.
